// File: rtl/mbox_tx_pkg.sv
// Shared definitions for the mailbox transmit interface.
//   - Wishbone register offsets (decoded on wb_adr_i[3:2])
//   - STATUS bit positions, given as offsets above the level field [FIFO_AW:0]
//   - CTRL bit positions
//   - serialiser state encoding
package mbox_tx_pkg;

  localparam logic [1:0] REG_TX_DATA = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_TX_CNT  = 2'd3;

  // STATUS flag bit = FIFO_AW + ST_*
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_BUSY  = 3;
  localparam int ST_OVF   = 4;
  localparam int ST_MFULL = 5;
  localparam int ST_MAFUL = 6;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_IRQ_EN  = 2;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/mbox_word_fifo.sv
// Synchronous word FIFO, show-ahead read (dout is the head entry).
//   clk, rst_n : clock, synchronous active-low reset
//   push, din  : write; ignored when full unless pop is taken in the same cycle
//   pop, dout  : remove head; ignored when empty
//   flush      : empty the FIFO (wins over push/pop)
//   full, empty, level : occupancy, level is 0..2**AW
module mbox_word_fifo #(
  parameter int DW = 36,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  localparam int DEPTH = 2**AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_d, wr_q, rd_d, rd_q;
  logic          do_push, do_pop;

  // Extra MSB on the pointers tells full from empty when the indices match.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level   = wr_q - rd_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + (AW+1)'(1);
      if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mbox_tx_if.sv
// Wishbone slave feeding a byte-lane mailbox write port.
//   wb_*        : Wishbone slave (registered ack and read data)
//   mbox_wr_o   : mailbox write strobe, mbox_do_o the lane being offered
//   mbox_full_i : mailbox backpressure, mbox_afull_i status only
//   irq_o       : overflow, or (irq_en and nothing left to send)
// CPU words are queued with their byte enables; the serialiser emits the
// enabled lanes least-significant first and skips disabled ones.
module mbox_tx_if
  import mbox_tx_pkg::*;
#(
  parameter int WB_AW         = 4,
  parameter int WB_DW         = 32,
  parameter int WOU_DW        = 8,
  parameter int FIFO_AW       = 4,
  parameter int BLOCK_ON_FULL = 1,
  parameter int CNT_W         = 32
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_ni,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  input  logic                       wb_we_i,
  input  logic [WB_DW/WOU_DW-1:0]    wb_sel_i,
  input  logic [WB_AW-1:2]           wb_adr_i,
  input  logic [WB_DW-1:0]           wb_dat_i,
  output logic [WB_DW-1:0]           wb_dat_o,
  output logic                       wb_ack_o,
  output logic                       mbox_wr_o,
  output logic [WOU_DW-1:0]          mbox_do_o,
  input  logic                       mbox_full_i,
  input  logic                       mbox_afull_i,
  output logic                       irq_o
);
  localparam int NL = WB_DW / WOU_DW;
  localparam int EW = WB_DW + NL;

  logic [1:0]        adr;
  logic              req, tx_wr, stall, acc_wr;
  logic              ack_d, ack_q;
  logic [WB_DW-1:0]  dat_d, dat_q, rdata, status;
  logic              ovf_d, ovf_q, irq_en_d, irq_en_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  state_e            state_d, state_q;
  logic [WB_DW-1:0]  word_d, word_q;
  logic [NL-1:0]     mask_d, mask_q, lane_oh;
  logic [WOU_DW-1:0] lane_dat;
  logic              mbox_wr, busy;
  logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [EW-1:0]     fifo_dout;
  logic [FIFO_AW:0]  fifo_level;

  assign adr   = wb_adr_i[3:2];
  assign req   = wb_cyc_i & wb_stb_i;
  assign tx_wr = req & wb_we_i & (adr == REG_TX_DATA);
  assign stall = (BLOCK_ON_FULL != 0) & tx_wr & fifo_full;
  // ack_d high is the accept: the access takes effect on the edge ack rises.
  assign ack_d  = req & ~ack_q & ~stall;
  assign acc_wr = ack_d & wb_we_i;

  assign fifo_push  = acc_wr & (adr == REG_TX_DATA);
  assign fifo_flush = acc_wr & (adr == REG_CTRL) & wb_dat_i[CTRL_FLUSH];

  mbox_word_fifo #(.DW(EW), .AW(FIFO_AW)) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   ({wb_sel_i, wb_dat_i}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Lowest remaining lane, isolated as a one-hot.
  always_comb begin
    lane_oh  = mask_q & (~mask_q + NL'(1));
    lane_dat = '0;
    for (int k = 0; k < NL; k++)
      if (lane_oh[k]) lane_dat = word_q[k*WOU_DW +: WOU_DW];
  end

  assign mbox_wr   = (state_q == S_SHIFT) & ~mbox_full_i & (|mask_q);
  // Gated so the strobe drops in the very cycle reset is asserted.
  assign mbox_wr_o = mbox_wr & wb_rst_ni;
  assign mbox_do_o = (state_q == S_SHIFT) ? lane_dat : '0;
  assign busy      = (state_q == S_SHIFT) | ~fifo_empty;
  assign irq_o     = ovf_q | (irq_en_q & fifo_empty & (state_q == S_IDLE));
  assign wb_ack_o  = ack_q;
  assign wb_dat_o  = dat_q;

  always_comb begin
    status                     = '0;
    status[FIFO_AW:0]          = fifo_level;
    status[FIFO_AW + ST_FULL]  = fifo_full;
    status[FIFO_AW + ST_EMPTY] = fifo_empty;
    status[FIFO_AW + ST_BUSY]  = busy;
    status[FIFO_AW + ST_OVF]   = ovf_q;
    status[FIFO_AW + ST_MFULL] = mbox_full_i;
    status[FIFO_AW + ST_MAFUL] = mbox_afull_i;
    rdata = '0;
    case (adr)
      REG_STATUS: rdata = status;
      REG_CTRL:   rdata[CTRL_IRQ_EN] = irq_en_q;
      REG_TX_CNT: rdata = WB_DW'(cnt_q);
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    fifo_pop = 1'b0;
    dat_d    = (ack_d & ~wb_we_i) ? rdata : '0;

    case (state_q)
      S_IDLE: if (!fifo_empty) begin
        fifo_pop          = 1'b1;
        {mask_d, word_d}  = fifo_dout;
        state_d           = S_SHIFT;
      end
      S_SHIFT: begin
        if (mbox_wr) begin
          mask_d = mask_q & ~lane_oh;
          cnt_d  = cnt_q + CNT_W'(1);
        end
        // Also retires an all-zero-mask word after one cycle.
        if (mask_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Drop-mode push into a full FIFO with no pop this cycle is lost.
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;

    if (acc_wr && adr == REG_CTRL) begin
      irq_en_d = wb_dat_i[CTRL_IRQ_EN];
      if (wb_dat_i[CTRL_CLR_OVF]) ovf_d = 1'b0;
      if (wb_dat_i[CTRL_FLUSH]) begin
        state_d = S_IDLE;
        mask_d  = '0;
      end
    end
    if (acc_wr && adr == REG_TX_CNT) cnt_d = '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      cnt_q    <= '0;
      state_q  <= S_IDLE;
      word_q   <= '0;
      mask_q   <= '0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      word_q   <= word_d;
      mask_q   <= mask_d;
    end
  end

endmodule

// File: tb/tb_mbox_tx_if.sv
// Bench: instance 0 stalls on full, instance 1 drops on full; both FIFO_AW=2.
module tb_mbox_tx_if;
  localparam int NL  = 4;
  localparam int FAW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cyc [2], stb [2], we [2];
  logic [3:0]  sel [2];
  logic [1:0]  adr [2];
  logic [31:0] dati [2], dato [2];
  logic        ack [2], mwr [2], mfull [2], mafull [2], irq [2];
  logic [7:0]  mdo [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mbox_tx_if #(
      .WB_AW(4), .WB_DW(32), .WOU_DW(8), .FIFO_AW(FAW),
      .BLOCK_ON_FULL(g == 0 ? 1 : 0), .CNT_W(32)
    ) u_dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .wb_cyc_i(cyc[g]), .wb_stb_i(stb[g]), .wb_we_i(we[g]),
      .wb_sel_i(sel[g]), .wb_adr_i(adr[g]), .wb_dat_i(dati[g]),
      .wb_dat_o(dato[g]), .wb_ack_o(ack[g]),
      .mbox_wr_o(mwr[g]), .mbox_do_o(mdo[g]),
      .mbox_full_i(mfull[g]), .mbox_afull_i(mafull[g]), .irq_o(irq[g])
    );
  end

  int errs = 0, checks = 0;
  bit rand_mf = 1'b0;
  logic [7:0] got0[$], got1[$], exp0[$], exp1[$];

  // Record every lane the mailbox would capture on the coming edge.
  always @(negedge clk) begin
    if (mwr[0]) got0.push_back(mdo[0]);
    if (mwr[1]) got1.push_back(mdo[1]);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mf) mfull[0] = ($urandom_range(0, 2) == 0);
  endtask

  task automatic xfer(input int d, input logic w, input logic [1:0] a,
                      input logic [31:0] data, input logic [3:0] s,
                      output logic [31:0] rdat);
    int n = 0;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dati[d] = data; sel[d] = s;
    do begin tick(); n++; end while (!ack[d] && n < 200);
    if (!ack[d]) chk("ack_timeout", ack[d], 1);
    rdat = dato[d];
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
  endtask

  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] data, input logic [3:0] s);
    logic [31:0] dummy;
    xfer(d, 1'b1, a, data, s, dummy);
  endtask

  task automatic rd(input int d, input logic [1:0] a, output logic [31:0] v);
    xfer(d, 1'b0, a, 32'h0, 4'hF, v);
  endtask

  // Reference: enabled lanes of a word in ascending lane order.
  task automatic expect_word(input int d, input logic [31:0] w, input logic [3:0] s);
    for (int k = 0; k < NL; k++)
      if (s[k]) begin
        if (d == 0) exp0.push_back(w[8*k +: 8]);
        else        exp1.push_back(w[8*k +: 8]);
      end
  endtask

  task automatic cmp_stream(input int d, input string tag);
    logic [7:0] g[$], e[$];
    if (d == 0) begin g = got0; e = exp0; got0.delete(); exp0.delete(); end
    else        begin g = got1; e = exp1; got1.delete(); exp1.delete(); end
    chk({tag, "_len"}, g.size(), e.size());
    for (int i = 0; i < e.size() && i < g.size(); i++) chk(tag, g[i], e[i]);
  endtask

  function automatic logic [31:0] st(int lvl, bit ovf, bit busy, bit mf, bit maf);
    logic [31:0] v;
    v = 32'(lvl);
    v[FAW+1] = (lvl == (1 << FAW));
    v[FAW+2] = (lvl == 0);
    v[FAW+3] = busy;
    v[FAW+4] = ovf;
    v[FAW+5] = mf;
    v[FAW+6] = maf;
    return v;
  endfunction

  task automatic wait_got0(input int target);
    int n = 0;
    while (got0.size() < target && n < 100) begin tick(); n++; end
    if (got0.size() < target) chk("wait_lane_timeout", got0.size(), target);
  endtask

  initial begin
    logic [31:0] r, w, w6;
    logic [3:0]  s, s6;
    int          n, cnt0;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 0; stb[d] = 0; we[d] = 0; sel[d] = 0; adr[d] = 0; dati[d] = 0; mfull[d] = 0;
    end
    mafull[0] = 1'b0; mafull[1] = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack", ack[d], 0);
      chk("rst_dat", dato[d], 0);
      chk("rst_wr",  mwr[d], 0);
      chk("rst_do",  mdo[d], 0);
      chk("rst_irq", irq[d], 0);
    end
    rst_n = 1'b1;
    tick();
    rd(0, 2'd1, r); chk("rst_status", r, st(0, 0, 0, 0, 0));
    cnt0 = 0;

    // Full word, exact lane timing.
    w = 32'h44332211;
    wr(0, 2'd0, w, 4'hF);
    expect_word(0, w, 4'hF);
    chk("lat_not_yet", mwr[0], 0);
    for (int i = 0; i < NL; i++) begin
      tick();
      chk("lat_wr", mwr[0], 1);
      chk("lat_do", mdo[0], w[8*i +: 8]);
    end
    tick();
    chk("lat_end", mwr[0], 0);
    cnt0 += 4;
    rd(0, 2'd3, r); chk("cnt_full_word", r, cnt0);
    cmp_stream(0, "s1_stream");

    // Sparse mask, then empty mask.
    wr(0, 2'd0, 32'hAABBCCDD, 4'b0101);
    expect_word(0, 32'hAABBCCDD, 4'b0101);
    repeat (8) tick();
    cnt0 += 2;
    rd(0, 2'd3, r); chk("cnt_sparse", r, cnt0);
    wr(0, 2'd0, $urandom, 4'b0000);
    repeat (8) tick();
    rd(0, 2'd3, r); chk("cnt_zero_mask", r, cnt0);
    cmp_stream(0, "s2_stream");

    // Backpressure in mid-word.
    w = 32'h0D0C0B0A;
    wr(0, 2'd0, w, 4'hF);
    expect_word(0, w, 4'hF);
    wait_got0(2);
    mfull[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_wr", mwr[0], 0);
      chk("hold_do", mdo[0], w[23:16]);
    end
    mfull[0] = 1'b0;
    repeat (8) tick();
    cnt0 += 4;
    cmp_stream(0, "s3_stream");

    // Random words under random backpressure.
    rand_mf = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w = $urandom; s = 4'($urandom_range(0, 15));
      wr(0, 2'd0, w, s);
      expect_word(0, w, s);
      cnt0 += $countones(s);
    end
    rand_mf = 1'b0;
    mfull[0] = 1'b0;
    repeat (60) tick();
    cmp_stream(0, "rand_stream");
    rd(0, 2'd3, r); chk("rand_cnt", r, cnt0);

    // Stall mode: ack withheld while full, released after first pop.
    mfull[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      wr(0, 2'd0, w, 4'hF);
      expect_word(0, w, 4'hF);
    end
    rd(0, 2'd1, r); chk("blk_status", r, st(4, 0, 1, 1, 0));
    w6 = $urandom; s6 = 4'($urandom_range(1, 15));
    cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 2'd0; dati[0] = w6; sel[0] = s6;
    for (int i = 0; i < 5; i++) begin tick(); chk("blk_stall", ack[0], 0); end
    mfull[0] = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!ack[0] && n < 50);
    // NL lanes drain, the pop edge follows, ack rises one edge later.
    chk("blk_ack_delay", n, NL + 2);
    cyc[0] = 0; stb[0] = 0; we[0] = 0;
    tick();
    chk("blk_ack_once", ack[0], 0);
    expect_word(0, w6, s6);
    repeat (40) tick();
    cmp_stream(0, "blk_stream");
    cnt0 += 20 + $countones(s6);

    // Drop mode: overflow on the 6th write.
    mfull[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      wr(1, 2'd0, w, 4'hF);
      if (i < 5) expect_word(1, w, 4'hF);
    end
    rd(1, 2'd1, r); chk("drp_status", r, st(4, 1, 1, 1, 1));
    chk("drp_irq", irq[1], 1);
    wr(1, 2'd2, 32'h2, 4'hF);
    rd(1, 2'd1, r); chk("drp_clr_status", r, st(4, 0, 1, 1, 1));
    chk("drp_clr_irq", irq[1], 0);
    mfull[1] = 1'b0;
    repeat (40) tick();
    cmp_stream(1, "drp_stream");
    rd(1, 2'd1, r); chk("drp_idle_status", r, st(0, 0, 0, 0, 1));
    wr(1, 2'd2, 32'h4, 4'hF);
    chk("irq_en_idle", irq[1], 1);
    rd(1, 2'd2, r); chk("ctrl_read", r, 32'h4);

    // Flush after two lanes of the in-flight word, three words queued.
    mfull[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      wr(0, 2'd0, w, 4'hF);
      if (i == 0) begin exp0.push_back(w[7:0]); exp0.push_back(w[15:8]); end
    end
    mfull[0] = 1'b0;
    wait_got0(2);
    mfull[0] = 1'b1;
    wr(0, 2'd2, 32'h1, 4'hF);
    mfull[0] = 1'b0;
    rd(0, 2'd1, r); chk("flush_status", r, st(0, 0, 0, 0, 0));
    repeat (10) tick();
    cmp_stream(0, "flush_stream");
    cnt0 += 2;
    rd(0, 2'd3, r); chk("flush_cnt", r, cnt0);

    // Reset in mid-word.
    w = $urandom;
    wr(0, 2'd0, w, 4'hF);
    exp0.push_back(w[7:0]);
    wait_got0(1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_wr", mwr[0], 0);
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst2_ack", ack[d], 0);
      chk("rst2_dat", dato[d], 0);
      chk("rst2_wr",  mwr[d], 0);
      chk("rst2_do",  mdo[d], 0);
      chk("rst2_irq", irq[d], 0);
    end
    rst_n = 1'b1;
    tick();
    cmp_stream(0, "rst_stream");
    rd(0, 2'd3, r); chk("rst_cnt", r, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
